hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, max EX/MEM wait cycles before abort.
REQ-002 SHALL have port CLK  in  1  single clock; all state updates on posedge.
REQ-003 SHALL have port RSTn  in  1  synchronous reset, active-low.
REQ-004 SHALL have ports Rs1D, Rs2D, Rs1E, Rs2E  in  5 each  source registers in D and E.
REQ-005 SHALL have ports RdE, RdM, RdW  in  5 each  destination registers in E, M, W.
REQ-006 SHALL have ports RegWriteM, RegWriteW  in  1 each  register-write enables in M, W.
REQ-007 SHALL have port ResultSrcE0  in  1  high when the E instruction is a load.
REQ-008 SHALL have port PCSrcE  in  1  branch/jump taken in E.
REQ-009 SHALL have ports MemReqM  in  1  data access in M; MemReadyM  in  1  data memory ack.
REQ-010 SHALL have ports ForwardAE, ForwardBE  out  2 each  operand forward select.
REQ-011 SHALL have ports StallF, StallD, StallE, StallM  out  1 each  hold PC, IF/ID, ID/EX, EX/MEM.
REQ-012 SHALL have ports FlushD, FlushE, FlushW  out  1 each  bubble IF/ID, ID/EX, MEM/WB.
REQ-013 SHALL have port MemErr  out  1  sticky memory-timeout flag.

Function
REQ-014 ForwardAE SHALL be 10 if RegWriteM, RdM==Rs1E, Rs1E!=0; else 01 if RegWriteW, RdW==Rs1E, Rs1E!=0; else 00 (ForwardBE identical on Rs2E).
REQ-015 Load-use SHALL be ResultSrcE0 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D); it asserts StallF, StallD, FlushE.
REQ-016 PCSrcE SHALL assert FlushD and FlushE; on simultaneous load-use, branch wins (no StallF/StallD).
REQ-017 Memory-wait FSM SHALL have states IDLE, WAIT, ABORT.
REQ-018 IDLE->WAIT when MemReqM && !MemReadyM; access with MemReadyM in same cycle completes with zero stall.
REQ-019 In WAIT, cycle counter SHALL increment each cycle; WAIT->IDLE when MemReadyM; WAIT->ABORT when counter==MEM_TIMEOUT and !MemReadyM.
REQ-020 ABORT SHALL set MemErr, release the pipeline as if ready, and return to IDLE next cycle.
REQ-021 Mem stall (IDLE with MemReqM&&!MemReadyM, or WAIT with !MemReadyM) SHALL assert StallF/D/E/M and FlushW, and SHALL mask load-use and branch flush outputs.
REQ-022 MemReadyM in WAIT SHALL deassert all mem-stall outputs in that same cycle (combinational release).
REQ-023 Counter SHALL clear on entering WAIT; width clog2(MEM_TIMEOUT+1).

Reset
REQ-024 With RSTn low at posedge: state=IDLE, counter=0, MemErr=0.
REQ-025 While RSTn low: Stall*=0, Forward*=00, FlushD/FlushE/FlushW=1.
REQ-026 Reset during WAIT SHALL abandon the access with no ABORT and no MemErr.

Configuration
REQ-027 With HAZARD_PERF_EN defined: outputs LuStallCnt, MemWaitCnt, FlushCnt (32 bits each) count load-use stall cycles, mem-stall cycles, branch-flush cycles; saturate at 0xFFFFFFFF; reset to 0.
REQ-028 Without HAZARD_PERF_EN: those ports and counters SHALL not exist; other behaviour identical.

Structure
REQ-029 Shared package hazard_pkg SHALL hold FWD_NONE=00, FWD_W=01, FWD_M=10 and the mem FSM state enum.
REQ-030 Memory-wait FSM plus timeout counter SHALL be sub-module mem_wait_fsm; forwarding/load-use/branch logic stays in hazard_ctrl.

Verification
REQ-031 Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10; RegWriteM=0 -> 01; Rs1E=0 -> 00.
REQ-032 ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 one cycle; add PCSrcE=1 -> FlushD=FlushE=1, StallF=0.
REQ-033 MemReqM=1, MemReadyM low 3 cycles then high -> StallM=FlushW=1 exactly 3 cycles, 0 on ready cycle, MemErr=0.
REQ-034 MEM_TIMEOUT=4, MemReadyM never high -> ABORT after 5 WAIT cycles, MemErr=1 sticky, stalls released.
REQ-035 Mem stall concurrent with PCSrcE=1 -> FlushD=FlushE=0 until release, then branch flush.
REQ-036 HAZARD_PERF_EN, 3-cycle mem wait plus one load-use -> MemWaitCnt=3, LuStallCnt=1; RSTn low mid-WAIT -> counters 0, MemErr 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit: forward selects, the
// memory-wait FSM state type and small helpers used by hazard_ctrl.
package hazard_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } memState_e;

    // Register 0 is hardwired, so it never needs a bypass; M is younger than W and wins.
    function automatic logic [1:0] fwdSel(input logic       regWrM,
                                          input logic [4:0] rdM,
                                          input logic       regWrW,
                                          input logic [4:0] rdW,
                                          input logic [4:0] rs);
        if (rs == 5'd0)                return FWD_NONE;
        if (regWrM && (rdM == rs))     return FWD_M;
        if (regWrW && (rdW == rs))     return FWD_W;
        return FWD_NONE;
    endfunction

    function automatic logic [31:0] satInc(input logic [31:0] value, input logic en);
        return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Data-memory handshake seen by the hazard unit: request in M and the memory ack.
interface hazard_ctrl_if;

    logic MemReqM;
    logic MemReadyM;

    modport master (output MemReqM, output MemReadyM);
    modport slave  (input  MemReqM, input  MemReadyM);

endinterface

// File: rtl/mem_wait_fsm.sv
// Tracks an outstanding data-memory access, stalls while it is not acked and
// aborts it with a sticky error once MEM_TIMEOUT wait cycles have elapsed.
module mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic memReq_i,
    input  logic memReady_i,
    output logic memStall_o,
    output logic memErr_o
);

    localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    memState_e        state_q;
    logic [CNT_W-1:0] waitCnt_q;
    logic             memErr_q;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            memErr_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (memReq_i && !memReady_i) begin
                        state_q   <= WAIT;
                        waitCnt_q <= '0;
                    end
                end
                WAIT: begin
                    if (memReady_i) begin
                        state_q <= IDLE;
                    end else if (waitCnt_q == CNT_MAX) begin
                        state_q  <= ABORT;
                        memErr_q <= 1'b1;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
                end
                ABORT:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Ready releases the stall in the same cycle; ABORT releases as if ready.
    assign memStall_o = !memReady_i && (((state_q == IDLE) && memReq_i) || (state_q == WAIT));
    assign memErr_o   = memErr_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and
// memory-wait stalls. Defining HAZARD_PERF_EN adds saturating event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic [4:0]   Rs1D,
    input  logic [4:0]   Rs2D,
    input  logic [4:0]   Rs1E,
    input  logic [4:0]   Rs2E,
    input  logic [4:0]   RdE,
    input  logic [4:0]   RdM,
    input  logic [4:0]   RdW,
    input  logic         RegWriteM,
    input  logic         RegWriteW,
    input  logic         ResultSrcE0,
    input  logic         PCSrcE,
    hazard_ctrl_if.slave memBus,
    output logic [1:0]   ForwardAE,
    output logic [1:0]   ForwardBE,
    output logic         StallF,
    output logic         StallD,
    output logic         StallE,
    output logic         StallM,
    output logic         FlushD,
    output logic         FlushE,
    output logic         FlushW,
    output logic         MemErr
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]  LuStallCnt,
    output logic [31:0]  MemWaitCnt,
    output logic [31:0]  FlushCnt
`endif
);

    logic memStall;
    logic loadUse;

    mem_wait_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) uMemWait (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .memReq_i   (memBus.MemReqM),
        .memReady_i (memBus.MemReadyM),
        .memStall_o (memStall),
        .memErr_o   (MemErr)
    );

    assign loadUse = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // A memory stall freezes everything up to M, so load-use and branch actions wait for release.
    always_comb begin
        ForwardAE = FWD_NONE;
        ForwardBE = FWD_NONE;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        if (!RSTn) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            ForwardAE = fwdSel(RegWriteM, RdM, RegWriteW, RdW, Rs1E);
            ForwardBE = fwdSel(RegWriteM, RdM, RegWriteW, RdW, Rs2E);
            if (memStall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = loadUse && !PCSrcE;
                StallD = loadUse && !PCSrcE;
                FlushD = PCSrcE;
                FlushE = PCSrcE || loadUse;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] luStallCnt_q;
    logic [31:0] memWaitCnt_q;
    logic [31:0] flushCnt_q;
    logic        luEvt;
    logic        flushEvt;

    assign luEvt    = loadUse && !PCSrcE && !memStall;
    assign flushEvt = PCSrcE && !memStall;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            luStallCnt_q <= '0;
            memWaitCnt_q <= '0;
            flushCnt_q   <= '0;
        end else begin
            luStallCnt_q <= satInc(luStallCnt_q, luEvt);
            memWaitCnt_q <= satInc(memWaitCnt_q, memStall);
            flushCnt_q   <= satInc(flushCnt_q, flushEvt);
        end
    end

    assign LuStallCnt = luStallCnt_q;
    assign MemWaitCnt = memWaitCnt_q;
    assign FlushCnt   = flushCnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand-written
// memory-wait sequences and a randomized run against a cycle-level model.
module tb_hazard_ctrl;

    localparam int TIMEOUT = 4;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW, ResultSrcE0, PCSrcE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
`ifdef HAZARD_PERF_EN
    logic [31:0] LuStallCnt, MemWaitCnt, FlushCnt;
`endif

    int compared = 0;
    int failed   = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl_if memIf ();

    hazard_ctrl #(
        .MEM_TIMEOUT(TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RdM         (RdM),
        .RdW         (RdW),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .ResultSrcE0 (ResultSrcE0),
        .PCSrcE      (PCSrcE),
        .memBus      (memIf),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushW      (FlushW),
        .MemErr      (MemErr)
`ifdef HAZARD_PERF_EN
        ,
        .LuStallCnt  (LuStallCnt),
        .MemWaitCnt  (MemWaitCnt),
        .FlushCnt    (FlushCnt)
`endif
    );

    typedef struct {
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic       regWrM, regWrW, ldE, pc;
        logic [1:0] fwdA, fwdB;
        logic [6:0] ctl;
    } vec_t;

    vec_t vecs [12];

    // Control outputs packed as {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
    function automatic logic [6:0] ctlNow();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    endfunction

    function automatic logic [1:0] fwdRef(input logic [4:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != 5'd0 && RegWriteW && RdW == rs) sel = 2'b01;
        if (rs != 5'd0 && RegWriteM && RdM == rs) sel = 2'b10;
        return sel;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic clearInputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteM, RegWriteW, ResultSrcE0, PCSrcE} = '0;
        memIf.MemReqM   = 1'b0;
        memIf.MemReadyM = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        Rs1D = v.rs1D; Rs2D = v.rs2D; Rs1E = v.rs1E; Rs2E = v.rs2E;
        RdE = v.rdE; RdM = v.rdM; RdW = v.rdW;
        RegWriteM = v.regWrM; RegWriteW = v.regWrW;
        ResultSrcE0 = v.ldE; PCSrcE = v.pc;
        memIf.MemReqM = 1'b0; memIf.MemReadyM = 1'b0;
    endtask

    task automatic memStep(input string tag, input logic req, input logic ready,
                           input logic expStall, input logic expErr);
        memIf.MemReqM = req; memIf.MemReadyM = ready;
        @(negedge CLK);
        checkOutput({tag, " stall"}, 32'({StallF, StallD, StallE, StallM, FlushW}), 32'({5{expStall}}));
        checkOutput({tag, " MemErr"}, 32'(MemErr), 32'(expErr));
        nextCycle();
    endtask

    initial begin
        vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 7'b0000000};
        vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 7'b0000000};
        vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 7'b0000000};
        vecs[3]  = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 7'b0000000};
        vecs[4]  = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd4, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 7'b0000000};
        vecs[5]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 7'b1100010};
        vecs[6]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 7'b0000110};
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 7'b0000000};
        vecs[8]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 7'b0000000};
        vecs[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 7'b0000110};
        vecs[10] = '{5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 7'b0000000};
        vecs[11] = '{5'd6, 5'd0, 5'd6, 5'd6, 5'd6, 5'd6, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b10, 7'b1100010};

        // Reset must mask forwarding, stalls and force the three flushes.
        clearInputs();
        RSTn = 1'b0;
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
        ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        memIf.MemReqM = 1'b1;
        @(negedge CLK);
        checkOutput("reset ctl", 32'(ctlNow()), 32'(7'b0000111));
        checkOutput("reset fwdA", 32'(ForwardAE), 32'(2'b00));
        checkOutput("reset MemErr", 32'(MemErr), 32'(1'b0));
        nextCycle();
        clearInputs();
        RSTn = 1'b1;

        // Three not-ready cycles, then ready releases in that same cycle.
        memStep("wait3 c0", 1'b1, 1'b0, 1'b1, 1'b0);
        memStep("wait3 c1", 1'b1, 1'b0, 1'b1, 1'b0);
        memStep("wait3 c2", 1'b1, 1'b0, 1'b1, 1'b0);
        memStep("wait3 rdy", 1'b1, 1'b1, 1'b0, 1'b0);
        memStep("zeroStall", 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(vecs[5]);
        @(negedge CLK);
        checkOutput("lu single ctl", 32'(ctlNow()), 32'(7'b1100010));
        nextCycle();
        clearInputs();
        @(negedge CLK);
`ifdef HAZARD_PERF_EN
        checkOutput("perf MemWaitCnt", MemWaitCnt, 32'd3);
        checkOutput("perf LuStallCnt", LuStallCnt, 32'd1);
        checkOutput("perf FlushCnt", FlushCnt, 32'd0);
`endif
        nextCycle();

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            @(negedge CLK);
            checkOutput($sformatf("vec%0d fwdA", i), 32'(ForwardAE), 32'(vecs[i].fwdA));
            checkOutput($sformatf("vec%0d fwdB", i), 32'(ForwardBE), 32'(vecs[i].fwdB));
            checkOutput($sformatf("vec%0d ctl", i), 32'(ctlNow()), 32'(vecs[i].ctl));
            nextCycle();
        end
        clearInputs();

        // Branch taken during a memory stall flushes only after release.
        PCSrcE = 1'b1; memIf.MemReqM = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checkOutput($sformatf("brStall c%0d ctl", i), 32'(ctlNow()), 32'(7'b1111001));
            nextCycle();
        end
        memIf.MemReadyM = 1'b1;
        @(negedge CLK);
        checkOutput("brRelease ctl", 32'(ctlNow()), 32'(7'b0000110));
        nextCycle();
        clearInputs();

        // Never ready: one IDLE stall cycle plus TIMEOUT+1 WAIT cycles, then abort.
        for (int i = 0; i < TIMEOUT + 2; i++)
            memStep($sformatf("abort c%0d", i), 1'b1, 1'b0, 1'b1, 1'b0);
        memStep("abort rel", 1'b0, 1'b0, 1'b0, 1'b1);
        memStep("sticky a", 1'b0, 1'b0, 1'b0, 1'b1);
        memStep("sticky b", 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-WAIT abandons the access and clears the error.
        memStep("rstWait c0", 1'b1, 1'b0, 1'b1, 1'b1);
        memStep("rstWait c1", 1'b1, 1'b0, 1'b1, 1'b1);
        RSTn = 1'b0;
        @(negedge CLK);
        checkOutput("rstWait ctl", 32'(ctlNow()), 32'(7'b0000111));
        nextCycle();
        RSTn = 1'b1;
        memStep("postRst idle", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_PERF_EN
        checkOutput("postRst MemWaitCnt", MemWaitCnt, 32'd0);
        checkOutput("postRst LuStallCnt", LuStallCnt, 32'd0);
        checkOutput("postRst FlushCnt", FlushCnt, 32'd0);
`endif
        memStep("postRst ready", 1'b1, 1'b1, 1'b0, 1'b0);
        clearInputs();

        randomRun();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

    // Model: an access stalls until acked; the cycle after TIMEOUT+2 stalled cycles is the abort.
    task automatic randomRun();
        int          stalledSoFar = -1;
        bit          errSticky    = 1'b0;
        int unsigned luCnt = 0, mwCnt = 0, flCnt = 0;
        bit          expStall, loadUse, req, ready;
        logic [6:0]  expCtl;
        for (int i = 0; i < 800; i++) begin
            RSTn = (i == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
            Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
            Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
            RdE  = 5'($urandom_range(0, 7)); RdM  = 5'($urandom_range(0, 7));
            RdW  = 5'($urandom_range(0, 7));
            RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
            ResultSrcE0 = ($urandom_range(0, 2) == 0);
            PCSrcE = ($urandom_range(0, 5) == 0);
            req   = ($urandom_range(0, 2) == 0);
            ready = ((i / 80) % 2 == 1) ? ($urandom_range(0, 9) == 0) : 1'($urandom_range(0, 1));
            memIf.MemReqM = req; memIf.MemReadyM = ready;
            @(negedge CLK);
            if (!RSTn) begin
                checkOutput("rnd rst ctl", 32'(ctlNow()), 32'(7'b0000111));
                checkOutput("rnd rst fwd", 32'({ForwardAE, ForwardBE}), 32'(4'b0000));
                stalledSoFar = -1; errSticky = 1'b0;
                luCnt = 0; mwCnt = 0; flCnt = 0;
            end else begin
                expStall = 1'b0;
                if (stalledSoFar < 0) begin
                    if (req && !ready) begin expStall = 1'b1; stalledSoFar = 1; end
                end else if (stalledSoFar == TIMEOUT + 2) begin
                    errSticky = 1'b1; stalledSoFar = -1;
                end else if (ready) begin
                    stalledSoFar = -1;
                end else begin
                    expStall = 1'b1; stalledSoFar++;
                end
                loadUse = ResultSrcE0 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
                if (expStall) expCtl = 7'b1111001;
                else expCtl = {loadUse && !PCSrcE, loadUse && !PCSrcE, 2'b00, PCSrcE, PCSrcE || loadUse, 1'b0};
                checkOutput($sformatf("rnd%0d ctl", i), 32'(ctlNow()), 32'(expCtl));
                checkOutput($sformatf("rnd%0d fwdA", i), 32'(ForwardAE), 32'(fwdRef(Rs1E)));
                checkOutput($sformatf("rnd%0d fwdB", i), 32'(ForwardBE), 32'(fwdRef(Rs2E)));
                checkOutput($sformatf("rnd%0d MemErr", i), 32'(MemErr), 32'(errSticky));
`ifdef HAZARD_PERF_EN
                checkOutput($sformatf("rnd%0d LuStallCnt", i), LuStallCnt, luCnt);
                checkOutput($sformatf("rnd%0d MemWaitCnt", i), MemWaitCnt, mwCnt);
                checkOutput($sformatf("rnd%0d FlushCnt", i), FlushCnt, flCnt);
`endif
                if (!expStall && loadUse && !PCSrcE) luCnt++;
                if (expStall) mwCnt++;
                if (!expStall && PCSrcE) flCnt++;
            end
            nextCycle();
        end
        clearInputs();
    endtask

endmodule
